score_keeper: RTL and testbench
===============================

# score_keeper

Tracks the doodle's climb during a run, converts it into a saturating 5-digit BCD score, and keeps a session high score. It sits beside `doodle` and feeds the `ultra_beam_substance_painter` as an extra overlay layer. It consumes `doodle_y` and `game_state`, and uses `beam_x`/`beam_y` to emit a per-pixel color plus transparency flag for the score digits.

## Interface
Parameters:
- `PX_PER_POINT`, default 16: upward screen pixels per point; power of two, 2..64.
- `ORIGIN_X`, default 8: left x of the score text.
- `ORIGIN_Y`, default 8: top y of the score text.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset; one clock, synchronous active-high reset.
- `frame_tick`  in  1  one-cycle pulse per frame (top level drives `fps_counter == 0`).
- `game_state`  in  2  0 = MENU, 1 = PLAYING, 2 = GAME_OVER, 3 = treated as MENU.
- `doodle_y`  in  10  doodle screen y; smaller means higher on screen.
- `beam_x`  in  11  current pixel x.
- `beam_y`  in  10  current pixel y.
- `score`  out  20  5 BCD digits, most significant digit in [19:16].
- `high_score`  out  20  5 BCD digits.
- `new_record`  out  1  one-cycle pulse when `high_score` is updated.
- `color`  out  12  `[2:0][3:0]` RGB of the overlay pixel.
- `is_transparent`  out  1  1 means the painter ignores `color`.

## Operation
- FSM states are IDLE, RUN, FLUSH and OVER.
  - IDLE → RUN when `game_state == PLAYING`. On that transition, `score`, `pending` and the remainder are cleared, and `prev_valid` is cleared.
  - RUN → FLUSH when `game_state == GAME_OVER`.
  - FLUSH → OVER when `pending == 0`.
  - OVER → RUN when `game_state == PLAYING`; the same clears as on IDLE → RUN apply.
  - Any state → IDLE on MENU or on state 3. `score` is held on this transition; only entering RUN clears it.
- Climb measurement, on `frame_tick` in RUN only:
  - If `prev_valid == 0`: load `prev_y <= doodle_y`, set `prev_valid`, and give no credit.
  - Otherwise, if `doodle_y < prev_y`, compute the 11-bit sum `acc = remainder + (prev_y - doodle_y)`. Then `pending += acc / PX_PER_POINT` and `remainder <= acc % PX_PER_POINT`.
  - Falling or level frames give no credit and never decrease the score. `prev_y <= doodle_y` on every tick.
- `pending` is a 7-bit counter that saturates at 127.
- Drain: in RUN or FLUSH, when `pending != 0`, each clock does `pending -= 1` and `score` gets +1 BCD with full ripple carry in the same cycle.
  - If a `frame_tick` add and a drain land in the same cycle: `pending <= sat(pending + new - 1)`.
- Saturation: when `score == 99999`, increments are dropped, `pending` is forced to 0 and the score stays at 99999.
- Commit on the FLUSH → OVER transition cycle: if `score > high_score`, then `high_score <= score` and `new_record` pulses for one cycle. Equal scores do not pulse.
- `high_score` survives MENU and restarts. Only `rst` clears it.
- Rendering (combinational from beam and registered state):
  - Glyphs are 4x6, scaled x2, giving 8x12 pixels per digit.
  - Digit cell pitch is 10 px; digit k (0 = most significant) spans x in [ORIGIN_X+10k, ORIGIN_X+10k+8).
  - Row 0 shows `score` at y in [ORIGIN_Y, ORIGIN_Y+12).
  - Row 1 shows `high_score` at y in [ORIGIN_Y+16, ORIGIN_Y+28), in OVER only.
  - A set glyph bit gives `color = 12'h000`, `is_transparent = 0`. Anything else is transparent.
  - Rows are shown in RUN, FLUSH and OVER. In IDLE everything is transparent.
  - Glyph "0": rows 1111,1001,1001,1001,1001,1111. All digits 0-9 are in an internal ROM.

## Timing
- Reset values: `score = 0`, `high_score = 0`, `new_record = 0`, `pending = 0`, `remainder = 0`, `prev_valid = 0`, state IDLE, `is_transparent = 1`, `color = 12'h000`.
- `game_state` is sampled every clock. FSM transitions take effect on the next edge.
- Points credited by a tick are visible on `score` starting 2 cycles after the tick. N pending points finish draining N cycles after the tick's update.
- The FLUSH duration equals the residual `pending`, 0..127 cycles.
- `new_record` is asserted the cycle after the FLUSH → OVER edge, for one cycle.
- Pixel outputs have zero latency relative to `beam_x`/`beam_y` (same cycle), matching the other sprite layers.
- Asserting `rst` in any state returns all outputs to their reset values on the next edge; `high_score` is lost.

## Test plan
- Reset, then PLAYING with `PX_PER_POINT = 16`; tick at `doodle_y = 400`, then tick at 368 → `score = 00002` within 3 cycles of the second tick, `remainder = 0`.
- Climb 10 px then another 10 px → no point after the first tick; `score = 00001` after the second, `remainder = 4`. A fall of 50 px afterwards → no change.
- Preload `score = 00999` via 999 credited points; one more point → `01000`. Drive 99998 then 5 points → `99999`, `pending = 0`.
- Run to `score = 00012` with `high_score = 00010`, then GAME_OVER → FLUSH, `high_score = 00012`, one `new_record` pulse. PLAYING again → `score = 0`, `high_score` stays `00012`. Scoring 12 again → no pulse.
- GAME_OVER asserted with `pending = 5` → FLUSH lasts 5 cycles, and the commit uses the final score.
- In RUN with `score = 0`: beam at (8,8) → opaque `12'h000`; beam at (10,10) → transparent (glyph hole); beam at (0,0) → transparent. In IDLE, beam at (8,8) → transparent.

Source files
------------

// File: rtl/score_keeper.sv
// score_keeper: climb-to-points tracker with saturating BCD score,
// session high score, and a two-row digit overlay for the painter.
module score_keeper #(
    parameter int PX_PER_POINT = 16,
    parameter int ORIGIN_X     = 8,
    parameter int ORIGIN_Y     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [1:0]  game_state,
    input  logic [9:0]  doodle_y,
    input  logic [10:0] beam_x,
    input  logic [9:0]  beam_y,
    output logic [19:0] score,
    output logic [19:0] high_score,
    output logic        new_record,
    output logic [11:0] color,
    output logic        is_transparent
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam int          SHIFT     = $clog2(PX_PER_POINT);
    localparam logic [5:0]  REM_MASK  = 6'(PX_PER_POINT - 1);
    localparam logic [19:0] SCORE_MAX = 20'h99999;

    state_t      state_q, state_d;
    logic [19:0] score_q, score_d;
    logic [19:0] high_q, high_d;
    logic        new_record_q, new_record_d;
    logic [6:0]  pending_q, pending_d;
    logic [5:0]  rem_q, rem_d;
    logic [9:0]  prev_y_q, prev_y_d;
    logic        prev_valid_q, prev_valid_d;

    logic gs_menu, gs_play, gs_over;
    logic start_run, commit, active, drain, at_max;
    logic [10:0] climb, acc, pts, sum;

    // +1 on a 5-digit packed BCD value with full digit ripple
    function automatic logic [19:0] bcd_inc(input logic [19:0] v);
        logic [19:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // 4x6 glyph ROM; bit 3 of a row is the leftmost column
    function automatic logic [3:0] glyph_row(input logic [3:0] d,
                                             input logic [2:0] row);
        logic [23:0] g;
        unique case (d)
            4'd0:    g = 24'hF9999F;
            4'd1:    g = 24'h262227;
            4'd2:    g = 24'hF1F88F;
            4'd3:    g = 24'hF1711F;
            4'd4:    g = 24'h99F111;
            4'd5:    g = 24'hF8F11F;
            4'd6:    g = 24'hF8F99F;
            4'd7:    g = 24'hF12444;
            4'd8:    g = 24'hF9F99F;
            4'd9:    g = 24'hF9F11F;
            default: g = 24'h000000;
        endcase
        unique case (row)
            3'd0:    return g[23:20];
            3'd1:    return g[19:16];
            3'd2:    return g[15:12];
            3'd3:    return g[11:8];
            3'd4:    return g[7:4];
            3'd5:    return g[3:0];
            default: return 4'h0;
        endcase
    endfunction

    assign gs_menu = (game_state == 2'd0) || (game_state == 2'd3);
    assign gs_play = (game_state == 2'd1);
    assign gs_over = (game_state == 2'd2);

    // Next-state: menu (or the unused code) always wins and parks in IDLE
    always_comb begin
        state_d = state_q;
        if (gs_menu) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (gs_play) state_d = RUN;
                RUN:     if (gs_over) state_d = FLUSH;
                FLUSH:   if (pending_q == 7'd0) state_d = OVER;
                OVER:    if (gs_play) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    assign start_run = (state_q == IDLE || state_q == OVER) && (state_d == RUN);
    assign commit    = (state_q == FLUSH) && (state_d == OVER);
    assign active    = (state_q == RUN) || (state_q == FLUSH);
    assign at_max    = (score_q == SCORE_MAX);
    assign drain     = active && (pending_q != 7'd0) && !at_max;

    // Climb credit, pending drain into the BCD score, and high-score commit
    always_comb begin
        score_d      = score_q;
        high_d       = high_q;
        new_record_d = 1'b0;
        rem_d        = rem_q;
        prev_y_d     = prev_y_q;
        prev_valid_d = prev_valid_q;
        climb        = {1'b0, prev_y_q} - {1'b0, doodle_y};
        acc          = {5'd0, rem_q} + climb;
        pts          = 11'd0;

        if (state_q == RUN && frame_tick) begin
            prev_y_d     = doodle_y;
            prev_valid_d = 1'b1;
            if (prev_valid_q && (doodle_y < prev_y_q)) begin
                pts   = acc >> SHIFT;
                rem_d = acc[5:0] & REM_MASK;
            end
        end

        sum       = {4'd0, pending_q} + pts - {10'd0, drain};
        pending_d = (sum > 11'd127) ? 7'd127 : sum[6:0];

        if (drain) begin
            score_d = bcd_inc(score_q);
        end

        // A maxed-out score swallows any further credit
        if (active && at_max) begin
            pending_d = 7'd0;
        end

        if (commit && (score_q > high_q)) begin
            high_d       = score_q;
            new_record_d = 1'b1;
        end

        if (start_run) begin
            score_d      = 20'd0;
            pending_d    = 7'd0;
            rem_d        = 6'd0;
            prev_valid_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            score_q      <= 20'd0;
            high_q       <= 20'd0;
            new_record_q <= 1'b0;
            pending_q    <= 7'd0;
            rem_q        <= 6'd0;
            prev_y_q     <= 10'd0;
            prev_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            high_q       <= high_d;
            new_record_q <= new_record_d;
            pending_q    <= pending_d;
            rem_q        <= rem_d;
            prev_y_q     <= prev_y_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    logic [11:0] dx;
    logic [10:0] dy;
    logic [19:0] val;
    logic [2:0]  grow;
    logic [1:0]  gcol;
    logic [3:0]  digit;
    logic [3:0]  rbits;
    logic        row_hit, col_hit, pix_on;

    // Same-cycle pixel lookup: score row always, high-score row in OVER
    always_comb begin
        dx      = {1'b0, beam_x} - 12'(ORIGIN_X);
        dy      = {1'b0, beam_y} - 11'(ORIGIN_Y);
        val     = score_q;
        grow    = 3'd0;
        gcol    = 2'd0;
        digit   = 4'd0;
        row_hit = 1'b0;
        col_hit = 1'b0;

        if ({1'b0, beam_y} >= 11'(ORIGIN_Y)) begin
            if (dy < 11'd12) begin
                row_hit = (state_q != IDLE);
                val     = score_q;
                grow    = dy[3:1];
            end else if (dy >= 11'd16 && dy < 11'd28) begin
                row_hit = (state_q == OVER);
                val     = high_q;
                grow    = 3'((dy - 11'd16) >> 1);
            end
        end

        if ({1'b0, beam_x} >= 12'(ORIGIN_X)) begin
            for (int k = 0; k < 5; k++) begin
                if (dx >= 12'(10 * k) && dx < 12'(10 * k + 8)) begin
                    col_hit = 1'b1;
                    gcol    = 2'((dx - 12'(10 * k)) >> 1);
                    digit   = val[4*(4-k) +: 4];
                end
            end
        end

        rbits  = glyph_row(digit, grow);
        pix_on = row_hit && col_hit && rbits[2'd3 - gcol];
    end

    assign score          = score_q;
    assign high_score     = high_q;
    assign new_record     = new_record_q;
    assign color          = 12'h000;
    assign is_transparent = !pix_on;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed scenarios for score_keeper with
// hand-computed expectations at PX_PER_POINT = 16, origin (8,8).
module tb_score_keeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic [1:0]  game_state;
    logic [9:0]  doodle_y;
    logic [10:0] beam_x;
    logic [9:0]  beam_y;
    logic [19:0] score;
    logic [19:0] high_score;
    logic        new_record;
    logic [11:0] color;
    logic        is_transparent;

    int pass_cnt  = 0;
    int total_cnt = 0;

    score_keeper #(
        .PX_PER_POINT(16),
        .ORIGIN_X(8),
        .ORIGIN_Y(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_tick(frame_tick),
        .game_state(game_state),
        .doodle_y(doodle_y),
        .beam_x(beam_x),
        .beam_y(beam_y),
        .score(score),
        .high_score(high_score),
        .new_record(new_record),
        .color(color),
        .is_transparent(is_transparent)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [9:0] y);
        doodle_y   = y;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic restart();
        game_state = 2'd0;
        step();
        game_state = 2'd1;
        step();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (dut.pending_q != 7'd0 && n < 400) begin
            step();
            n++;
        end
    endtask

    task automatic game_over(output int flush_n, output int pulses);
        game_state = 2'd2;
        step();
        flush_n = 0;
        while (dut.state_q == 2'd2 && flush_n < 300) begin
            flush_n++;
            step();
        end
        pulses = int'(new_record);
        step();
        pulses += int'(new_record);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        frame_tick = 1'b0;
        game_state = 2'd0;
        doodle_y   = 10'd0;
        beam_x     = 11'd8;
        beam_y     = 10'd8;
        step();
        step();
        rst = 1'b0;
        total_cnt++;
        if (score !== 20'h00000)
            $display("FAIL reset_score got %h want %h", score, 20'h0);
        else pass_cnt++;
        total_cnt++;
        if (high_score !== 20'h00000)
            $display("FAIL reset_high got %h want %h", high_score, 20'h0);
        else pass_cnt++;
        total_cnt++;
        if (new_record !== 1'b0)
            $display("FAIL reset_new_record got %b want 0", new_record);
        else pass_cnt++;
        total_cnt++;
        if (is_transparent !== 1'b1 || color !== 12'h000)
            $display("FAIL reset_pixel got t=%b c=%h want t=1 c=000",
                     is_transparent, color);
        else pass_cnt++;
    endtask

    task automatic test_climb();
        int n;
        game_state = 2'd1;
        step();
        tick(10'd400);
        tick(10'd368);
        n = 0;
        while (score !== 20'h00002 && n < 3) begin
            step();
            n++;
        end
        total_cnt++;
        if (score !== 20'h00002)
            $display("FAIL climb_score got %h want %h", score, 20'h00002);
        else pass_cnt++;
        total_cnt++;
        if (dut.rem_q !== 6'd0)
            $display("FAIL climb_rem got %0d want 0", dut.rem_q);
        else pass_cnt++;
    endtask

    task automatic test_remainder();
        restart();
        tick(10'd400);
        tick(10'd390);
        step();
        step();
        total_cnt++;
        if (score !== 20'h00000 || dut.rem_q !== 6'd10)
            $display("FAIL rem_first got %h/%0d want 00000/10",
                     score, dut.rem_q);
        else pass_cnt++;
        tick(10'd380);
        step();
        step();
        total_cnt++;
        if (score !== 20'h00001 || dut.rem_q !== 6'd4)
            $display("FAIL rem_second got %h/%0d want 00001/4",
                     score, dut.rem_q);
        else pass_cnt++;
        tick(10'd430);
        step();
        step();
        step();
        total_cnt++;
        if (score !== 20'h00001 || dut.rem_q !== 6'd4)
            $display("FAIL rem_fall got %h/%0d want 00001/4",
                     score, dut.rem_q);
        else pass_cnt++;
    endtask

    task automatic test_carry_and_saturation();
        restart();
        tick(10'd1000);
        for (int r = 0; r < 19; r++) begin
            tick(10'd200);
            tick(10'd1000);
            wait_drain();
        end
        tick(10'd216);
        wait_drain();
        total_cnt++;
        if (score !== 20'h00999)
            $display("FAIL carry_999 got %h want %h", score, 20'h00999);
        else pass_cnt++;
        tick(10'd1000);
        tick(10'd984);
        wait_drain();
        total_cnt++;
        if (score !== 20'h01000)
            $display("FAIL carry_1000 got %h want %h", score, 20'h01000);
        else pass_cnt++;
        force dut.score_q = 20'h99998;
        step();
        release dut.score_q;
        tick(10'd904);
        for (int i = 0; i < 8; i++) step();
        total_cnt++;
        if (score !== 20'h99999 || dut.pending_q !== 7'd0)
            $display("FAIL sat_score got %h/%0d want 99999/0",
                     score, dut.pending_q);
        else pass_cnt++;
        tick(10'd1000);
        tick(10'd600);
        for (int i = 0; i < 4; i++) step();
        total_cnt++;
        if (score !== 20'h99999 || dut.pending_q !== 7'd0)
            $display("FAIL sat_hold got %h/%0d want 99999/0",
                     score, dut.pending_q);
        else pass_cnt++;
    endtask

    task automatic test_record();
        int fl, pu;
        restart();
        tick(10'd1000);
        tick(10'd840);
        wait_drain();
        game_over(fl, pu);
        total_cnt++;
        if (high_score !== 20'h00010 || pu !== 1 || dut.state_q !== 2'd3)
            $display("FAIL rec_first got high=%h pulses=%0d st=%0d want 00010/1/3",
                     high_score, pu, dut.state_q);
        else pass_cnt++;
        beam_x = 11'd8;
        beam_y = 10'd24;
        #1;
        total_cnt++;
        if (is_transparent !== 1'b0)
            $display("FAIL rec_row1_over got t=%b want 0", is_transparent);
        else pass_cnt++;
        game_state = 2'd1;
        step();
        total_cnt++;
        if (score !== 20'h0 || high_score !== 20'h00010 || is_transparent !== 1'b1)
            $display("FAIL rec_restart got %h/%h t=%b want 00000/00010 t=1",
                     score, high_score, is_transparent);
        else pass_cnt++;
        tick(10'd1000);
        tick(10'd808);
        wait_drain();
        total_cnt++;
        if (score !== 20'h00012)
            $display("FAIL rec_score12 got %h want %h", score, 20'h00012);
        else pass_cnt++;
        game_over(fl, pu);
        total_cnt++;
        if (high_score !== 20'h00012 || pu !== 1)
            $display("FAIL rec_new got high=%h pulses=%0d want 00012/1",
                     high_score, pu);
        else pass_cnt++;
        game_state = 2'd1;
        step();
        total_cnt++;
        if (score !== 20'h0 || high_score !== 20'h00012)
            $display("FAIL rec_keep got %h/%h want 00000/00012",
                     score, high_score);
        else pass_cnt++;
        tick(10'd1000);
        tick(10'd808);
        wait_drain();
        game_over(fl, pu);
        total_cnt++;
        if (high_score !== 20'h00012 || pu !== 0)
            $display("FAIL rec_equal got high=%h pulses=%0d want 00012/0",
                     high_score, pu);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        int fl, pu;
        game_state = 2'd1;
        step();
        tick(10'd1000);
        tick(10'd872);
        wait_drain();
        tick(10'd1000);
        tick(10'd920);
        game_over(fl, pu);
        total_cnt++;
        if (fl !== 5)
            $display("FAIL flush_len got %0d want 5", fl);
        else pass_cnt++;
        total_cnt++;
        if (score !== 20'h00013 || high_score !== 20'h00013 || pu !== 1)
            $display("FAIL flush_commit got %h/%h pulses=%0d want 00013/00013/1",
                     score, high_score, pu);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        game_state = 2'd1;
        step();
        tick(10'd1000);
        tick(10'd968);
        tick(10'd936);
        total_cnt++;
        if (dut.pending_q !== 7'd3 || score !== 20'h00001)
            $display("FAIL b2b_pending got %0d/%h want 3/00001",
                     dut.pending_q, score);
        else pass_cnt++;
        wait_drain();
        total_cnt++;
        if (score !== 20'h00004)
            $display("FAIL b2b_score got %h want %h", score, 20'h00004);
        else pass_cnt++;
    endtask

    task automatic test_pixels();
        game_state = 2'd0;
        step();
        beam_x = 11'd8;
        beam_y = 10'd8;
        #1;
        total_cnt++;
        if (is_transparent !== 1'b1)
            $display("FAIL pix_idle got t=%b want 1", is_transparent);
        else pass_cnt++;
        game_state = 2'd1;
        step();
        total_cnt++;
        if (is_transparent !== 1'b0 || color !== 12'h000)
            $display("FAIL pix_8_8 got t=%b c=%h want t=0 c=000",
                     is_transparent, color);
        else pass_cnt++;
        beam_x = 11'd10;
        beam_y = 10'd10;
        #1;
        total_cnt++;
        if (is_transparent !== 1'b1)
            $display("FAIL pix_hole got t=%b want 1", is_transparent);
        else pass_cnt++;
        beam_x = 11'd0;
        beam_y = 10'd0;
        #1;
        total_cnt++;
        if (is_transparent !== 1'b1)
            $display("FAIL pix_origin got t=%b want 1", is_transparent);
        else pass_cnt++;
        beam_x = 11'd16;
        beam_y = 10'd8;
        #1;
        total_cnt++;
        if (is_transparent !== 1'b1)
            $display("FAIL pix_gap got t=%b want 1", is_transparent);
        else pass_cnt++;
        beam_x = 11'd18;
        #1;
        total_cnt++;
        if (is_transparent !== 1'b0)
            $display("FAIL pix_digit1 got t=%b want 0", is_transparent);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        beam_x = 11'd8;
        beam_y = 10'd8;
        #1;
        total_cnt++;
        if (score !== 20'h0 || high_score !== 20'h0 || is_transparent !== 1'b1)
            $display("FAIL mid_reset got %h/%h t=%b want 00000/00000 t=1",
                     score, high_score, is_transparent);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_climb();
        test_remainder();
        test_carry_and_saturation();
        test_record();
        test_flush();
        test_back_to_back();
        test_pixels();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
